// File: rtl/ram_master_pkg.sv
// rtl/ram_master_pkg.sv - shared parameters and state encoding for the RAM master
package ram_master_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 32;
  localparam int MAX_BURST_DEF = 4;

  // Width of the read burst length field (length minus one)
  localparam int LEN_W = 2;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE       = 2'd0;
  localparam state_t ST_WRITE      = 2'd1;
  localparam state_t ST_READ_ISSUE = 2'd2;
  localparam state_t ST_READ_DRAIN = 2'd3;

endpackage

// File: rtl/ram_master_if.sv
// rtl/ram_master_if.sv - core request/response and RAM port bundle for the RAM master
interface ram_master_if #(
  parameter int ADDR_W = ram_master_pkg::ADDR_W_DEF,
  parameter int DATA_W = ram_master_pkg::DATA_W_DEF
) ();
  import ram_master_pkg::*;

  // Core request side
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [DATA_W-1:0] req_wdata;

  // Core response side
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_last;
  logic              wr_done;

  // Single-port RAM side
  logic              ram_wr_en;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    input  req_valid, req_we, req_addr, req_len, req_wdata, ram_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, wr_done,
    output ram_wr_en, ram_address, ram_data_in
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, req_wdata, ram_data_out,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, wr_done,
    input  ram_wr_en, ram_address, ram_data_in
  );

endinterface

// File: rtl/ram_master.sv
// rtl/ram_master.sv - single-word write / short read-burst master for a single-port RAM
module ram_master
  import ram_master_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_master_if.master bus
);

  state_t            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beat_q, beat_d;
  logic              pipe_q, pipe_d;
  logic              pipe_last_q, pipe_last_d;
  logic              last_issue;

  // The final issue beat is the requested length, clamped to the burst limit
  assign last_issue = (beat_q == len_q) || (int'(beat_q) >= MAX_BURST - 1);

  // Request handshake and response outputs; read data passes straight through
  assign bus.req_ready   = (state_q == ST_IDLE);
  assign bus.wr_done     = (state_q == ST_WRITE);
  assign bus.rsp_valid   = pipe_q;
  assign bus.rsp_last    = pipe_last_q;
  assign bus.rsp_rdata   = bus.ram_data_out;
  assign bus.ram_wr_en   = wr_en_q;
  assign bus.ram_address = addr_q;
  assign bus.ram_data_in = wdata_q;

  // Next-state logic: accept in IDLE, issue one address per cycle, flag each issue one cycle later
  always_comb begin
    state_d     = state_q;
    wr_en_d     = 1'b0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    len_d       = len_q;
    beat_d      = beat_q;
    pipe_d      = 1'b0;
    pipe_last_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          if (bus.req_we) begin
            state_d = ST_WRITE;
            wr_en_d = 1'b1;
            wdata_d = bus.req_wdata;
          end else begin
            state_d = ST_READ_ISSUE;
            len_d   = bus.req_len;
            beat_d  = '0;
          end
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_READ_ISSUE: begin
        pipe_d = 1'b1;
        if (last_issue) begin
          pipe_last_d = 1'b1;
          state_d     = ST_READ_DRAIN;
        end else begin
          beat_d = beat_q + LEN_W'(1);
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      ST_READ_DRAIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and RAM-port registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wr_en_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      beat_q      <= '0;
      pipe_q      <= 1'b0;
      pipe_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      len_q       <= len_d;
      beat_q      <= beat_d;
      pipe_q      <= pipe_d;
      pipe_last_q <= pipe_last_d;
    end
  end

endmodule

// File: tb/tb_ram_master.sv
// tb/tb_ram_master.sv - directed self-checking bench for ram_master with a behavioural RAM
module tb_ram_master;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_fail;
  int n_rsp;
  int n_wr;
  int n_ovl;
  int n_wen_bad;
  bit mon_en;

  logic [31:0] mem [1024];

  ram_master_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  ram_master #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM: one-cycle read latency, read-before-write
  always @(posedge clk) begin
    if (bus.ram_wr_en === 1'b1) mem[bus.ram_address] <= bus.ram_data_in;
    bus.ram_data_out <= mem[bus.ram_address];
  end

  // Whole-run monitor of response/write pulses and their exclusivity
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.rsp_valid === 1'b1) n_rsp++;
      if (bus.wr_done === 1'b1) n_wr++;
      if (bus.rsp_valid === 1'b1 && bus.wr_done === 1'b1) n_ovl++;
      if (bus.ram_wr_en !== bus.wr_done) n_wen_bad++;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d);
    tick();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    chk("wr_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("wr_done", 32'(bus.wr_done), 32'd1);
    chk("wr_en", 32'(bus.ram_wr_en), 32'd1);
    chk("wr_addr", 32'(bus.ram_address), 32'(a));
    chk("wr_data", bus.ram_data_in, d);
    chk("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic do_read(input logic [9:0] a, input int n, input logic [3:0][31:0] exp);
    logic [9:0] ea;
    tick();
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    bus.req_len   = 2'(n - 1);
    chk("rd_ready", 32'(bus.req_ready), 32'd1);
    for (int c = 1; c <= n + 2; c++) begin
      tick();
      if (c == 1) bus.req_valid = 1'b0;
      if (c <= n) begin
        ea = a + 10'(c - 1);
        chk("rd_addr", 32'(bus.ram_address), 32'(ea));
        chk("rd_wren", 32'(bus.ram_wr_en), 32'd0);
      end
      if (c >= 2 && c <= n + 1) begin
        chk("rd_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rd_data", bus.rsp_rdata, exp[c-2]);
        chk("rd_last", 32'(bus.rsp_last), 32'(c == n + 1));
      end else begin
        chk("rd_idle_valid", 32'(bus.rsp_valid), 32'd0);
      end
      chk("rd_busy_ready", 32'(bus.req_ready), 32'(c == n + 2));
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; n_rsp = 0; n_wr = 0; n_ovl = 0; n_wen_bad = 0;
    mon_en = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_last", 32'(bus.rsp_last), 32'd0);
    chk("rst_wr_done", 32'(bus.wr_done), 32'd0);
    chk("rst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("rst_addr", 32'(bus.ram_address), 32'd0);
    chk("rst_wdata", bus.ram_data_in, 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    chk("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // Single write then single-word read back
    do_write(10'd5, 32'h766E2C96);
    do_read(10'd5, 1, {32'h0, 32'h0, 32'h0, 32'h766E2C96});

    // Four-word burst from address 0
    do_write(10'd0, 32'h11);
    do_write(10'd1, 32'h22);
    do_write(10'd2, 32'h33);
    do_write(10'd3, 32'h44);
    do_read(10'd0, 4, {32'h44, 32'h33, 32'h22, 32'h11});

    // Burst wrapping past the top of the address space
    do_write(10'd1022, 32'hAA1);
    do_write(10'd1023, 32'hAA2);
    do_read(10'd1022, 4, {32'h22, 32'h11, 32'hAA2, 32'hAA1});

    // Request held during a 2-word burst is taken once, only back in IDLE
    tick();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'd0; bus.req_len = 2'd1;
    chk("hold_accept_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_we = 1'b1; bus.req_addr = 10'd9; bus.req_wdata = 32'h55;
    chk("hold_t1_ready", 32'(bus.req_ready), 32'd0);
    chk("hold_t1_addr", 32'(bus.ram_address), 32'd0);
    tick();
    chk("hold_t2_ready", 32'(bus.req_ready), 32'd0);
    chk("hold_t2_data", bus.rsp_rdata, 32'h11);
    chk("hold_t2_last", 32'(bus.rsp_last), 32'd0);
    chk("hold_t2_wr_done", 32'(bus.wr_done), 32'd0);
    tick();
    chk("hold_t3_ready", 32'(bus.req_ready), 32'd0);
    chk("hold_t3_data", bus.rsp_rdata, 32'h22);
    chk("hold_t3_last", 32'(bus.rsp_last), 32'd1);
    chk("hold_t3_wr_done", 32'(bus.wr_done), 32'd0);
    tick();
    chk("hold_t4_ready", 32'(bus.req_ready), 32'd1);
    chk("hold_t4_wr_done", 32'(bus.wr_done), 32'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("hold_t5_wr_done", 32'(bus.wr_done), 32'd1);
    chk("hold_t5_addr", 32'(bus.ram_address), 32'd9);
    chk("hold_t5_wdata", bus.ram_data_in, 32'h55);
    tick();
    chk("hold_t6_wr_done", 32'(bus.wr_done), 32'd0);
    chk("hold_t6_ready", 32'(bus.req_ready), 32'd1);

    // Reset after the second issued address of a 4-word burst
    tick();
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 10'd0; bus.req_len = 2'd3;
    chk("mrst_ready", 32'(bus.req_ready), 32'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("mrst_addr0", 32'(bus.ram_address), 32'd0);
    tick();
    chk("mrst_addr1", 32'(bus.ram_address), 32'd1);
    chk("mrst_word0", bus.rsp_rdata, 32'h11);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_wr_en", 32'(bus.ram_wr_en), 32'd0);
    chk("mrst_addr", 32'(bus.ram_address), 32'd0);
    chk("mrst_ready_rst", 32'(bus.req_ready), 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mrst_quiet_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mrst_quiet_ready", 32'(bus.req_ready), 32'd1);
    end

    // Back-to-back write then read of the same word
    do_write(10'd7, 32'hDEADBEEF);
    do_read(10'd7, 1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF});

    tick();
    chk("total_rsp_beats", 32'(n_rsp), 32'd13);
    chk("total_wr_pulses", 32'(n_wr), 32'd9);
    chk("rsp_wr_overlap", 32'(n_ovl), 32'd0);
    chk("wr_en_outside_write", 32'(n_wen_bad), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
